// File: rtl/lc3_fetch_ctrl.sv
// lc3_fetch_ctrl: LC-3 program-counter sequencing FSM.
// Walks fetch (FETCH1..3), decodes the opcode, resolves BR and JMP/RET
// locally through Load_PC/PCMUX_Control and hands every other opcode to the
// execute controller with an Exec_Start pulse / Exec_Done handshake.
//
// Ports:
//   Clk, Reset           clock, asynchronous active-low reset
//   IR, NZP              instruction register, condition codes {N,Z,P}
//   Mem_R                memory read data valid
//   Exec_Done            execute controller finished
//   Soft_Restart         force PC to 0 and refetch (ignored in RST_WAIT)
//   Load_PC, PCMUX_Control  PC load / select (00 PC+1, 01 adder, 10 bus, 11 zero)
//   Gate_PC, Gate_BaseR  bus drivers
//   Load_MAR, Mem_En, Load_MDR, Load_IR  fetch datapath controls
//   Exec_Start           one-cycle execute start pulse
//   Fetch_Fault          sticky memory-timeout flag
//   State                current state encoding (debug)
//
// Optional feature: define FETCH_TIMEOUT_EN to bound FETCH2 waits to
// MEM_TIMEOUT cycles; on expiry the FSM parks in HALT with Fetch_Fault set.
module lc3_fetch_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    input  logic [2:0]  NZP,
    input  logic        Mem_R,
    input  logic        Exec_Done,
    input  logic        Soft_Restart,
    output logic        Load_PC,
    output logic [1:0]  PCMUX_Control,
    output logic        Gate_PC,
    output logic        Gate_BaseR,
    output logic        Load_MAR,
    output logic        Mem_En,
    output logic        Load_MDR,
    output logic        Load_IR,
    output logic        Exec_Start,
    output logic        Fetch_Fault,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        StRstWait  = 3'd0,
        StFetch1   = 3'd1,
        StFetch2   = 3'd2,
        StFetch3   = 3'd3,
        StDecode   = 3'd4,
        StBranch   = 3'd5,
        StExecWait = 3'd6,
        StHalt     = 3'd7
    } state_e;

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpJmp = 4'b1100;

    state_e     state_q, state_d;
    logic [3:0] opcode;
    logic       br_taken;
    logic       restart;
    logic       timeout;
    logic       unused_ir;

    assign opcode    = IR[15:12];
    assign br_taken  = |(IR[11:9] & NZP);
    assign restart   = Soft_Restart && (state_q != StRstWait);
    assign unused_ir = ^IR[8:0];

`ifdef FETCH_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_inc;
    logic            fault_q;

    assign to_cnt_inc  = to_cnt_q + TO_W'(1);
    // Expires on the MEM_TIMEOUT-th consecutive FETCH2 cycle without Mem_R.
    assign timeout     = (state_q == StFetch2) && !Mem_R
                         && (to_cnt_inc == TO_W'(MEM_TIMEOUT));
    assign Fetch_Fault = fault_q;
`else
    logic [TO_W-1:0] unused_to;

    assign unused_to   = TO_W'(MEM_TIMEOUT);
    assign timeout     = 1'b0;
    assign Fetch_Fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = StFetch1;
        end else begin
            case (state_q)
                StRstWait:  state_d = StFetch1;
                StFetch1:   state_d = StFetch2;
                StFetch2: begin
                    if (Mem_R)        state_d = StFetch3;
                    else if (timeout) state_d = StHalt;
                end
                StFetch3:   state_d = StDecode;
                StDecode: begin
                    if (opcode == OpBr)       state_d = br_taken ? StBranch : StFetch1;
                    else if (opcode == OpJmp) state_d = StFetch1;
                    else                      state_d = StExecWait;
                end
                StBranch:   state_d = StFetch1;
                StExecWait: if (Exec_Done) state_d = StFetch1;
                StHalt:     state_d = StHalt;
                default:    state_d = StRstWait;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StRstWait;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_q <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef FETCH_TIMEOUT_EN
            // Held at zero outside FETCH2, so every entry starts a fresh count.
            if (state_q != StFetch2) to_cnt_q <= '0;
            else if (!Mem_R)         to_cnt_q <= to_cnt_inc;
            if (restart)      fault_q <= 1'b0;
            else if (timeout) fault_q <= 1'b1;
`endif
        end
    end

    // Mem_R and Soft_Restart act in the same cycle, so outputs are decoded
    // from the state register plus those inputs.
    always_comb begin
        Load_PC       = 1'b0;
        PCMUX_Control = 2'b00;
        Gate_PC       = 1'b0;
        Gate_BaseR    = 1'b0;
        Load_MAR      = 1'b0;
        Mem_En        = 1'b0;
        Load_MDR      = 1'b0;
        Load_IR       = 1'b0;
        Exec_Start    = 1'b0;
        if (restart) begin
            Load_PC       = 1'b1;
            PCMUX_Control = 2'b11;
        end else begin
            case (state_q)
                StFetch1: begin
                    Gate_PC  = 1'b1;
                    Load_MAR = 1'b1;
                    Load_PC  = 1'b1;
                end
                StFetch2: begin
                    Mem_En   = 1'b1;
                    Load_MDR = Mem_R;
                end
                StFetch3: Load_IR = 1'b1;
                StDecode: begin
                    if (opcode == OpJmp) begin
                        Gate_BaseR    = 1'b1;
                        Load_PC       = 1'b1;
                        PCMUX_Control = 2'b10;
                    end else if (opcode != OpBr) begin
                        Exec_Start = 1'b1;
                    end
                end
                StBranch: begin
                    Load_PC       = 1'b1;
                    PCMUX_Control = 2'b01;
                end
                default: ;
            endcase
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Scoreboard bench for lc3_fetch_ctrl. The driver applies one cycle of
// inputs at a time and queues the expected {State, outputs} word for that
// cycle; the monitor pops and compares on every falling edge.
// Output word layout (14 bits):
//   {State[2:0], Load_PC, PCMUX[1:0], Gate_PC, Gate_BaseR, Load_MAR,
//    Mem_En, Load_MDR, Load_IR, Exec_Start, Fetch_Fault}
module tb_lc3_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] IR;
    logic [2:0]  NZP;
    logic        Mem_R, Exec_Done, Soft_Restart;
    logic        Load_PC, Gate_PC, Gate_BaseR, Load_MAR, Mem_En, Load_MDR, Load_IR;
    logic        Exec_Start, Fetch_Fault;
    logic [1:0]  PCMUX_Control;
    logic [2:0]  State;

    lc3_fetch_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .NZP(NZP), .Mem_R(Mem_R),
        .Exec_Done(Exec_Done), .Soft_Restart(Soft_Restart),
        .Load_PC(Load_PC), .PCMUX_Control(PCMUX_Control), .Gate_PC(Gate_PC),
        .Gate_BaseR(Gate_BaseR), .Load_MAR(Load_MAR), .Mem_En(Mem_En),
        .Load_MDR(Load_MDR), .Load_IR(Load_IR), .Exec_Start(Exec_Start),
        .Fetch_Fault(Fetch_Fault), .State(State)
    );

    always #5 Clk = ~Clk;

    // Expected output patterns (everything except State).
    //                             ldpc mux gpc gbr mar men mdr ir  es  ff
    localparam logic [10:0] ONONE = 11'b0___00__0___0___0___0___0___0___0___0;
    localparam logic [10:0] OF1   = 11'b1___00__1___0___1___0___0___0___0___0;
    localparam logic [10:0] OF2   = 11'b0___00__0___0___0___1___0___0___0___0;
    localparam logic [10:0] OF2R  = 11'b0___00__0___0___0___1___1___0___0___0;
    localparam logic [10:0] OF3   = 11'b0___00__0___0___0___0___0___1___0___0;
    localparam logic [10:0] OES   = 11'b0___00__0___0___0___0___0___0___1___0;
    localparam logic [10:0] OJMP  = 11'b1___10__0___1___0___0___0___0___0___0;
    localparam logic [10:0] OBRT  = 11'b1___01__0___0___0___0___0___0___0___0;
    localparam logic [10:0] OSR   = 11'b1___11__0___0___0___0___0___0___0___0;
    localparam logic [10:0] OFLT  = 11'b0___00__0___0___0___0___0___0___0___1;

    localparam logic [15:0] I_ADD = 16'h1021;
    localparam logic [15:0] I_BR  = 16'h0A05;
    localparam logic [15:0] I_RET = 16'hC1C0;

    typedef struct {
        logic [13:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] act;

    assign act = {State, Load_PC, PCMUX_Control, Gate_PC, Gate_BaseR, Load_MAR,
                  Mem_En, Load_MDR, Load_IR, Exec_Start, Fetch_Fault};

    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, act, e.v);
            end
        end
    end

    // One cycle of stimulus plus its expected outputs; called just after a posedge.
    task automatic step(input string name, input logic [15:0] ir, input logic [2:0] nzp,
                        input logic mr, input logic ed, input logic sr,
                        input logic [2:0] st, input logic [10:0] o);
        IR           = ir;
        NZP          = nzp;
        Mem_R        = mr;
        Exec_Done    = ed;
        Soft_Restart = sr;
        sb.push_back('{v: {st, o}, name: name});
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        IR = 16'h0; NZP = 3'b000; Mem_R = 1'b0; Exec_Done = 1'b0; Soft_Restart = 1'b0;
        @(posedge Clk);
        #1;
        // Reset held low; Soft_Restart is ignored in RST_WAIT.
        step("rst0", 16'h0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, ONONE);
        step("rst1", 16'h0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd0, ONONE);
        step("rst2", 16'h0, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0, ONONE);
        Reset = 1'b1;
        step("rst_rel", 16'h0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, ONONE);

        // ADD with four wait states; Exec_Done during DECODE is ignored.
        step("add_f1", I_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
        for (int i = 0; i < 4; i++)
            step("add_f2_wait", I_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd2, OF2);
        step("add_f2_rdy", I_ADD, 3'b010, 1'b1, 1'b0, 1'b0, 3'd2, OF2R);
        step("add_f3", I_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd3, OF3);
        step("add_dec", I_ADD, 3'b010, 1'b0, 1'b1, 1'b0, 3'd4, OES);
        step("add_ew0", I_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd6, ONONE);
        step("add_ew1", I_ADD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd6, ONONE);
        step("add_ew_done", I_ADD, 3'b010, 1'b0, 1'b1, 1'b0, 3'd6, ONONE);

        // BRnp, Z set: not taken.
        step("brnt_f1", I_BR, 3'b010, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
        step("brnt_f2", I_BR, 3'b010, 1'b1, 1'b0, 1'b0, 3'd2, OF2R);
        step("brnt_f3", I_BR, 3'b010, 1'b0, 1'b0, 1'b0, 3'd3, OF3);
        step("brnt_dec", I_BR, 3'b010, 1'b0, 1'b0, 1'b0, 3'd4, ONONE);
        // BRnp, N set: taken.
        step("brt_f1", I_BR, 3'b100, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
        step("brt_f2", I_BR, 3'b100, 1'b1, 1'b0, 1'b0, 3'd2, OF2R);
        step("brt_f3", I_BR, 3'b100, 1'b0, 1'b0, 1'b0, 3'd3, OF3);
        step("brt_dec", I_BR, 3'b100, 1'b0, 1'b0, 1'b0, 3'd4, ONONE);
        step("brt_branch", I_BR, 3'b100, 1'b0, 1'b0, 1'b0, 3'd5, OBRT);

        // RET.
        step("ret_f1", I_RET, 3'b001, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
        step("ret_f2", I_RET, 3'b001, 1'b1, 1'b0, 1'b0, 3'd2, OF2R);
        step("ret_f3", I_RET, 3'b001, 1'b0, 1'b0, 1'b0, 3'd3, OF3);
        step("ret_dec", I_RET, 3'b001, 1'b0, 1'b0, 1'b0, 3'd4, OJMP);

        // Soft restart mid-FETCH2, then a stale Mem_R in FETCH1.
        step("sr_f1", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
        step("sr_f2", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd2, OF2);
        step("sr_f2_restart", I_ADD, 3'b001, 1'b0, 1'b0, 1'b1, 3'd2, OSR);
        step("sr_stale_mr", I_ADD, 3'b001, 1'b1, 1'b0, 1'b0, 3'd1, OF1);
        step("sr2_f2", I_ADD, 3'b001, 1'b1, 1'b0, 1'b0, 3'd2, OF2R);
        step("sr2_f3", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd3, OF3);
        step("sr2_dec", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd4, OES);
        step("sr2_ew", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd6, ONONE);
        step("sr2_ew_restart", I_ADD, 3'b001, 1'b0, 1'b0, 1'b1, 3'd6, OSR);
        step("sr2_f1", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd1, OF1);

        // Memory never answers.
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 16; i++)
            step("to_f2_wait", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd2, OF2);
        step("to_halt0", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd7, OFLT);
        step("to_halt1", I_ADD, 3'b001, 1'b1, 1'b1, 1'b0, 3'd7, OFLT);
        step("to_halt_restart", I_ADD, 3'b001, 1'b0, 1'b0, 1'b1, 3'd7, OSR | OFLT);
        step("to_f1_clear", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
        // Mem_R on the expiry cycle wins.
        for (int i = 0; i < 15; i++)
            step("to2_f2_wait", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd2, OF2);
        step("to2_f2_last_rdy", I_ADD, 3'b001, 1'b1, 1'b0, 1'b0, 3'd2, OF2R);
        step("to2_f3", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd3, OF3);
`else
        for (int i = 0; i < 20; i++)
            step("nto_f2_wait", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd2, OF2);
        step("nto_restart", I_ADD, 3'b001, 1'b0, 1'b0, 1'b1, 3'd2, OSR);
        step("nto_f1", I_ADD, 3'b001, 1'b0, 1'b0, 1'b0, 3'd1, OF1);
`endif

        @(negedge Clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_ctrl.md
Name: lc3_fetch_ctrl

Overview:
- Moore/Mealy control FSM that sequences the LC-3 program counter datapath through instruction fetch, decode and PC-changing instructions.
- Resolves BR and JMP/RET locally by driving Load_PC and PCMUX_Control.
- Hands all other opcodes to the execute controller over a start/done handshake.
- Sits between the PC register/PCMUX block, the MAR/MDR/IR registers, and the memory interface.

Parameters:
- MEM_TIMEOUT, 16: maximum FETCH2 wait cycles for Mem_R (used only with FETCH_TIMEOUT_EN).
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IR  in  16  current instruction register contents.
- NZP  in  3  condition codes {N,Z,P} from the CC register.
- Mem_R  in  1  memory ready; read data valid this cycle.
- Exec_Done  in  1  execute controller finished the current instruction.
- Soft_Restart  in  1  synchronous request to force PC to 0 and refetch.
- Load_PC  out  1  PC register load enable.
- PCMUX_Control  out  2  PCMUX select: 00 PC+1, 01 adder, 10 bus, 11 zero.
- Gate_PC  out  1  drive PC onto the bus.
- Gate_BaseR  out  1  drive the BaseR register-file read port onto the bus.
- Load_MAR  out  1  MAR load enable.
- Mem_En  out  1  memory read request.
- Load_MDR  out  1  MDR load enable.
- Load_IR  out  1  IR load enable.
- Exec_Start  out  1  one-cycle pulse starting the execute controller.
- Fetch_Fault  out  1  sticky memory-timeout flag.
- State  out  3  current state encoding, for debug.

Behaviour:
- States (encoding): RST_WAIT=0, FETCH1=1, FETCH2=2, FETCH3=3, DECODE=4, BRANCH=5, EXEC_WAIT=6, HALT=7.
- Reset low (asynchronous): State=RST_WAIT and Fetch_Fault=0. Every output is 0 while in RST_WAIT.
- RST_WAIT -> FETCH1 on the first rising edge after Reset deasserts.
- FETCH1:
  - Gate_PC=1, Load_MAR=1, Load_PC=1, PCMUX_Control=00 (MAR<-PC, PC<-PC+1).
  - Always -> FETCH2.
- FETCH2:
  - Mem_En=1.
  - Load_MDR = Mem_R (Mealy output).
  - Mem_R=1 -> FETCH3; otherwise remain in FETCH2.
- FETCH3: Load_IR=1; -> DECODE.
- DECODE, by opcode IR[15:12]:
  - 0000 (BR): -> BRANCH if (IR[11:9] & NZP) != 0, else -> FETCH1. No outputs asserted.
  - 1100 (JMP/RET): Gate_BaseR=1, Load_PC=1, PCMUX_Control=10; -> FETCH1.
  - Any other opcode: Exec_Start=1 for exactly this cycle; -> EXEC_WAIT.
- BRANCH: Load_PC=1, PCMUX_Control=01 (PC<-PC+1+SEXT(offset9), computed by the external adder); -> FETCH1.
- EXEC_WAIT:
  - No outputs asserted.
  - Exec_Done=1 -> FETCH1.
  - Exec_Done asserted in the same cycle as Exec_Start is ignored; it is sampled only from EXEC_WAIT.
- HALT: all outputs 0 except Fetch_Fault; exited only by Soft_Restart.
- Soft_Restart:
  - Sampled in every state except RST_WAIT, with priority over all transitions.
  - That cycle: Load_PC=1 and PCMUX_Control=11; all other load/gate/mem/start outputs forced to 0.
  - Next state is FETCH1; Fetch_Fault clears.
  - A Soft_Restart during FETCH2 abandons the pending read; a late Mem_R is ignored.
- Default PCMUX_Control=00 whenever Load_PC=0.
- Gate_PC and Gate_BaseR are never both 1.
- Latencies:
  - Fetch of a non-branching instruction: 3 + w cycles to Load_IR, where w = wait cycles with Mem_R=0.
  - Taken BR: DECODE plus BRANCH, 2 cycles after FETCH3.
  - Not-taken BR and JMP: 1 cycle after FETCH3.
- BR with IR[11:9]=000 is never taken. BR with 111 is always taken, because exactly one NZP bit is set in normal operation.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to FETCH2 and increments each FETCH2 cycle with Mem_R=0.
  - When the count reaches MEM_TIMEOUT with Mem_R still 0: next state HALT, Fetch_Fault<=1 (sticky).
  - Mem_R=1 on the timeout cycle takes priority: normal -> FETCH3.
- Not defined: no counter; FETCH2 waits indefinitely, Fetch_Fault is tied to 0, and HALT is unreachable.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0 during reset; State 0 -> 1 on the first edge after release; FETCH1 shows Load_PC=1, PCMUX_Control=00, Gate_PC=1, Load_MAR=1.
- Mem_R low 4 cycles, then high, IR=0x1021 (ADD) -> Mem_En high 5 cycles; Load_MDR high only on the Mem_R cycle; Load_IR next cycle; Exec_Start one pulse; stays in EXEC_WAIT until Exec_Done, then FETCH1.
- IR=0x0A05 (BRnp) with NZP=010, then again with NZP=100 -> first: no Load_PC, back to FETCH1 after DECODE; second: BRANCH with Load_PC=1, PCMUX_Control=01.
- IR=0xC1C0 (RET) -> in DECODE: Gate_BaseR=1, Load_PC=1, PCMUX_Control=10, Gate_PC=0; next state FETCH1.
- Soft_Restart pulsed mid-FETCH2, then in EXEC_WAIT -> that cycle: Load_PC=1, PCMUX_Control=11, Mem_En=0; next state FETCH1; a stale Mem_R the following cycle causes no Load_MDR.
- FETCH_TIMEOUT_EN defined, MEM_TIMEOUT=16, Mem_R held 0 -> State=7 and Fetch_Fault=1 after 16 wait cycles; Soft_Restart clears Fetch_Fault and returns to FETCH1; with the macro undefined, the design stays in FETCH2 and Fetch_Fault=0.
